// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: shares one pipelined saturating MAC between two
// requesters. It grants round-robin per job, clears the accumulator,
// feeds LEN operand pairs, drains the MAC pipeline and returns the sum.
// Ports: clock, reset_n (async, active low); in_valid_k/in_a_k/in_b_k/
// in_ready_k per requester; mac_a/mac_b/mac_en/mac_clr/mac_sum to MAC;
// res_valid/res_ready/res_data/res_id/res_sat/res_err result channel.
// Optional build macro: MAC_SCHED_TIMEOUT_EN aborts a job whose
// producer stays idle for TIMEOUT consecutive FEED cycles.
module mac_job_scheduler #(
    parameter int LEN     = 4,
    parameter int MAC_LAT = 3,
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid_0,
    input  logic [7:0]  in_a_0,
    input  logic [7:0]  in_b_0,
    output logic        in_ready_0,
    input  logic        in_valid_1,
    input  logic [7:0]  in_a_1,
    input  logic [7:0]  in_b_1,
    output logic        in_ready_1,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic        mac_en,
    output logic        mac_clr,
    input  logic [15:0] mac_sum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic        res_sat,
    output logic        res_err
);

    // One width shared by the pair, drain and idle counters.
    localparam int MX1 = (LEN > MAC_LAT) ? LEN : MAC_LAT;
    localparam int MX  = (MX1 > TIMEOUT) ? MX1 : TIMEOUT;
    localparam int CW  = $clog2(MX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] DRN_INIT = CW'(MAC_LAT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dcnt;
    logic [1:0]    rdy_q;
    logic          clr_q;
    logic          vld_q;
    logic          id_q;
    logic [15:0]   data_q;
    logic          accept;

`ifdef MAC_SCHED_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] tcnt;
    logic          err_q;
`endif

    // rdy_q is one-hot (or zero) and only set in FEED, so the
    // handshake never depends combinationally on in_valid.
    assign accept = (rdy_q[0] & in_valid_0)
                  | (rdy_q[1] & in_valid_1);

    assign in_ready_0 = rdy_q[0];
    assign in_ready_1 = rdy_q[1];
    assign mac_en     = accept;
    assign mac_clr    = clr_q;
    assign res_valid  = vld_q;
    assign res_data   = data_q;
    assign res_id     = id_q;
    assign res_sat    = &data_q;

`ifdef MAC_SCHED_TIMEOUT_EN
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // Operands are zero whenever nobody holds the MAC.
    always_comb begin
        mac_a = 8'd0;
        mac_b = 8'd0;
        unique case (1'b1)
            rdy_q[0]: begin
                mac_a = in_a_0;
                mac_b = in_b_0;
            end
            rdy_q[1]: begin
                mac_a = in_a_1;
                mac_b = in_b_1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= '0;
            dcnt       <= '0;
            rdy_q      <= 2'b00;
            clr_q      <= 1'b0;
            vld_q      <= 1'b0;
            id_q       <= 1'b0;
            data_q     <= 16'd0;
`ifdef MAC_SCHED_TIMEOUT_EN
            tcnt       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            clr_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (in_valid_0 | in_valid_1) begin
                        // Tie goes to whoever was not served last.
                        if (in_valid_0 & in_valid_1)
                            grant <= ~last_grant;
                        else
                            grant <= in_valid_1;
                        clr_q <= 1'b1;
                        state <= S_CLEAR;
`ifdef MAC_SCHED_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    cnt   <= '0;
                    rdy_q <= grant ? 2'b10 : 2'b01;
                    state <= S_FEED;
`ifdef MAC_SCHED_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                S_FEED: begin
                    if (accept) begin
`ifdef MAC_SCHED_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (cnt == CNT_LAST) begin
                            rdy_q <= 2'b00;
                            cnt   <= '0;
                            dcnt  <= DRN_INIT;
                            state <= S_DRAIN;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
`ifdef MAC_SCHED_TIMEOUT_EN
                    else if (tcnt == TMO_LAST) begin
                        // Abort: wipe the partial sum, report error.
                        rdy_q  <= 2'b00;
                        cnt    <= '0;
                        tcnt   <= '0;
                        clr_q  <= 1'b1;
                        data_q <= 16'd0;
                        id_q   <= grant;
                        err_q  <= 1'b1;
                        vld_q  <= 1'b1;
                        state  <= S_RESULT;
                    end else begin
                        tcnt <= tcnt + ONE;
                    end
`endif
                end
                S_DRAIN: begin
                    // Last pair's contribution is on mac_sum now.
                    if (dcnt == ONE) begin
                        dcnt   <= '0;
                        data_q <= mac_sum;
                        id_q   <= grant;
                        vld_q  <= 1'b1;
                        state  <= S_RESULT;
                    end else begin
                        dcnt <= dcnt - ONE;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        vld_q      <= 1'b0;
                        last_grant <= grant;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb_mac_job_scheduler: directed bench for mac_job_scheduler with a
// cycle-accurate 3-stage saturating MAC model and scripted requesters.
module tb_mac_job_scheduler;

    localparam int LEN = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iv [2];
    logic [7:0]  ia [2];
    logic [7:0]  ib [2];
    logic        in_ready_0, in_ready_1;
    logic [7:0]  mac_a, mac_b;
    logic        mac_en, mac_clr;
    logic [15:0] mac_sum;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        res_id, res_sat, res_err;

    always #5 clock = ~clock;

    mac_job_scheduler #(.LEN(4), .MAC_LAT(3), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid_0(iv[0]), .in_a_0(ia[0]), .in_b_0(ib[0]),
        .in_ready_0(in_ready_0),
        .in_valid_1(iv[1]), .in_a_1(ia[1]), .in_b_1(ib[1]),
        .in_ready_1(in_ready_1),
        .mac_a(mac_a), .mac_b(mac_b),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_sum(mac_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .res_sat(res_sat), .res_err(res_err)
    );

    // MAC model: product visible on mac_sum 3 cycles after mac_en.
    logic [15:0] acc, p1, p2;
    logic [16:0] nsum;
    assign nsum    = {1'b0, acc} + {1'b0, p2};
    assign mac_sum = acc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= 16'd0; p1 <= 16'd0; p2 <= 16'd0;
        end else if (mac_clr) begin
            acc <= 16'd0; p1 <= 16'd0; p2 <= 16'd0;
        end else begin
            p1  <= mac_en ? ({8'd0, mac_a} * {8'd0, mac_b}) : 16'd0;
            p2  <= p1;
            acc <= nsum[16] ? 16'hFFFF : nsum[15:0];
        end
    end

    // Requester scripts and recorded observations.
    logic [7:0]  va [2][LEN];
    logic [7:0]  vb [2][LEN];
    bit          act [2];
    int          idx [2], start_at [2], stop_at [2];
    int          gap_at [2], gap_len [2], gap_cnt [2];
    int          hold;
    int          nres, clr_cnt, clr_first, unstable, wait_viol;
    logic [63:0] en_mask;
    logic [15:0] r_data [4];
    logic        r_id [4], r_sat [4], r_err [4];
    int          r_cyc [4];
    int          tests = 0;
    int          fails = 0;

    task automatic load(input int k, input logic [31:0] a,
                        input logic [31:0] b);
        for (int i = 0; i < LEN; i++) begin
            va[k][i] = a[8*i +: 8];
            vb[k][i] = b[8*i +: 8];
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; idx[k] = 0; start_at[k] = 0;
            stop_at[k] = LEN; gap_at[k] = -1;
            gap_len[k] = 0; gap_cnt[k] = 0;
        end
        hold = 0;
    endtask

    // Cycle 0 is the first negedge below; DUT must be in IDLE then.
    task automatic run(input int max_c, input int want);
        bit          pv;
        logic [15:0] pd;
        logic        pi, ps;
        int          cur, hl;
        logic [1:0]  rdy;
        nres = 0; clr_cnt = 0; clr_first = -1; en_mask = '0;
        unstable = 0; wait_viol = 0; pv = 0; cur = -1; hl = hold;
        pd = 16'd0; pi = 1'b0; ps = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_data[i] = 16'hDEAD; r_id[i] = 1'bx;
            r_sat[i] = 1'bx; r_err[i] = 1'bx; r_cyc[i] = -1;
        end
        for (int c = 0; c < max_c && nres < want; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (act[k] && c >= start_at[k] && idx[k] < stop_at[k]
                    && gap_cnt[k] == 0) begin
                    iv[k] = 1'b1;
                    ia[k] = va[k][idx[k]];
                    ib[k] = vb[k][idx[k]];
                end else begin
                    iv[k] = 1'b0;
                    if (gap_cnt[k] > 0) gap_cnt[k]--;
                end
            end
            res_ready = !(res_valid && hl > 0);
            #1;
            rdy = {in_ready_1, in_ready_0};
            if (mac_clr) begin
                clr_cnt++;
                if (clr_first < 0) clr_first = c;
            end
            if (mac_en && c < 64) en_mask[c] = 1'b1;
            if (res_valid && (mac_clr || mac_en || rdy != 2'b00))
                wait_viol++;
            if (res_valid && pv && (res_data !== pd || res_id !== pi
                || res_sat !== ps))
                unstable++;
            if (res_valid && !pv) cur = c;
            pv = res_valid && !res_ready;
            pd = res_data; pi = res_id; ps = res_sat;
            if (res_valid && res_ready) begin
                r_data[nres] = res_data; r_id[nres] = res_id;
                r_sat[nres] = res_sat; r_err[nres] = res_err;
                r_cyc[nres] = cur;
                nres++;
            end else if (res_valid && hl > 0) begin
                hl--;
            end
            for (int k = 0; k < 2; k++) begin
                if (iv[k] && rdy[k]) begin
                    if (idx[k] == gap_at[k]) gap_cnt[k] = gap_len[k];
                    idx[k]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        iv[0] = 1'b0; iv[1] = 1'b0; res_ready = 1'b0;
        ia[0] = 8'd0; ia[1] = 8'd0; ib[0] = 8'd0; ib[1] = 8'd0;
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({in_ready_0, in_ready_1, mac_a, mac_b, mac_en, mac_clr,
             res_valid, res_data, res_id, res_sat, res_err} !== 40'd0)
        begin
            fails++;
            $display("FAIL reset_outputs got rv=%b rd=%h rdy=%b%b",
                     res_valid, res_data, in_ready_1, in_ready_0);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_tie();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        load(1, 32'h02020202, 32'h03030303);
        act[0] = 1'b1; act[1] = 1'b1;
        run(60, 2);
        tests++;
        if (nres !== 2) begin
            fails++; $display("FAIL tie_count got %0d want 2", nres);
        end
        tests++;
        if (r_id[0] !== 1'b0 || r_data[0] !== 16'd70) begin
            fails++;
            $display("FAIL tie_first got id=%b d=%0d want id=0 d=70",
                     r_id[0], r_data[0]);
        end
        tests++;
        if (r_id[1] !== 1'b1 || r_data[1] !== 16'd24) begin
            fails++;
            $display("FAIL tie_second got id=%b d=%0d want id=1 d=24",
                     r_id[1], r_data[1]);
        end
        tests++;
        if (r_cyc[0] !== 9 || r_cyc[1] !== 19) begin
            fails++;
            $display("FAIL tie_cycles got %0d,%0d want 9,19",
                     r_cyc[0], r_cyc[1]);
        end
        clear_reqs();
        act[0] = 1'b1; act[1] = 1'b1;
        run(60, 2);
        tests++;
        if (nres !== 2 || r_id[0] !== 1'b0 || r_id[1] !== 1'b1) begin
            fails++;
            $display("FAIL tie_again got n=%0d ids=%b%b want 2 ids=01",
                     nres, r_id[0], r_id[1]);
        end
    endtask

    task automatic test_single();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        act[0] = 1'b1;
        run(40, 1);
        tests++;
        if (nres !== 1 || r_data[0] !== 16'd70) begin
            fails++;
            $display("FAIL single_data got n=%0d d=%0d want 1 d=70",
                     nres, r_data[0]);
        end
        tests++;
        if (r_id[0] !== 1'b0 || r_sat[0] !== 1'b0 || r_err[0] !== 1'b0)
        begin
            fails++;
            $display("FAIL single_flags got id=%b sat=%b err=%b want 000",
                     r_id[0], r_sat[0], r_err[0]);
        end
        tests++;
        if (r_cyc[0] !== 9) begin
            fails++;
            $display("FAIL single_latency got %0d want 9", r_cyc[0]);
        end
        tests++;
        if (clr_cnt !== 1 || clr_first !== 1) begin
            fails++;
            $display("FAIL single_clr got n=%0d at=%0d want 1 at 1",
                     clr_cnt, clr_first);
        end
        tests++;
        if (en_mask[15:0] !== 16'h003C) begin
            fails++;
            $display("FAIL single_en got %h want 003c", en_mask[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        // Requester 0 was served last, so this tie goes to 1.
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        load(1, 32'h02020202, 32'h03030303);
        act[0] = 1'b1; act[1] = 1'b1;
        run(60, 2);
        tests++;
        if (nres !== 2 || r_id[0] !== 1'b1 || r_id[1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_order got n=%0d ids=%b%b want 2 ids=10",
                     nres, r_id[0], r_id[1]);
        end
        tests++;
        if (r_data[0] !== 16'd24 || r_data[1] !== 16'd70) begin
            fails++;
            $display("FAIL b2b_data got %0d,%0d want 24,70",
                     r_data[0], r_data[1]);
        end
        tests++;
        if (clr_cnt !== 2) begin
            fails++; $display("FAIL b2b_clr got %0d want 2", clr_cnt);
        end
    endtask

    task automatic test_saturate();
        clear_reqs();
        load(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        act[1] = 1'b1;
        run(40, 1);
        tests++;
        if (nres !== 1 || r_data[0] !== 16'hFFFF || r_id[0] !== 1'b1)
        begin
            fails++;
            $display("FAIL sat_data got n=%0d d=%h id=%b want ffff id=1",
                     nres, r_data[0], r_id[0]);
        end
        tests++;
        if (r_sat[0] !== 1'b1) begin
            fails++; $display("FAIL sat_flag got %b want 1", r_sat[0]);
        end
    endtask

    task automatic test_gap();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        act[0] = 1'b1; gap_at[0] = 1; gap_len[0] = 2;
        run(40, 1);
        tests++;
        if (nres !== 1 || r_data[0] !== 16'd70) begin
            fails++;
            $display("FAIL gap_data got n=%0d d=%0d want 70",
                     nres, r_data[0]);
        end
        tests++;
        if (en_mask[15:0] !== 16'h00CC) begin
            fails++;
            $display("FAIL gap_en got %h want 00cc", en_mask[15:0]);
        end
        tests++;
        if (r_cyc[0] !== 11) begin
            fails++; $display("FAIL gap_latency got %0d want 11", r_cyc[0]);
        end
    endtask

    task automatic test_hold();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        load(1, 32'h02020202, 32'h03030303);
        act[0] = 1'b1; act[1] = 1'b1; start_at[1] = 3; hold = 5;
        run(60, 2);
        tests++;
        if (nres !== 2 || r_cyc[0] !== 9 || r_cyc[1] !== 24) begin
            fails++;
            $display("FAIL hold_cycles got n=%0d %0d,%0d want 9,24",
                     nres, r_cyc[0], r_cyc[1]);
        end
        tests++;
        if (unstable !== 0 || wait_viol !== 0) begin
            fails++;
            $display("FAIL hold_stable got unst=%0d viol=%0d want 0,0",
                     unstable, wait_viol);
        end
        tests++;
        if (r_data[0] !== 16'd70 || r_id[1] !== 1'b1
            || r_data[1] !== 16'd24) begin
            fails++;
            $display("FAIL hold_data got %0d,%b,%0d want 70,1,24",
                     r_data[0], r_id[1], r_data[1]);
        end
    endtask

    task automatic test_reset_feed();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        act[0] = 1'b1;
        run(4, 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({in_ready_0, in_ready_1, mac_a, mac_b, mac_en, mac_clr,
             res_valid, res_data, res_id, res_sat, res_err} !== 40'd0)
        begin
            fails++;
            $display("FAIL rst_feed_outputs got en=%b rdy=%b a=%h",
                     mac_en, in_ready_0, mac_a);
        end
        @(negedge clock);
        iv[0] = 1'b0;
        reset_n = 1'b1;
        clear_reqs();
        act[0] = 1'b1;
        run(40, 1);
        tests++;
        if (nres !== 1 || r_data[0] !== 16'd70 || r_cyc[0] !== 9) begin
            fails++;
            $display("FAIL rst_feed_resend got n=%0d d=%0d c=%0d",
                     nres, r_data[0], r_cyc[0]);
        end
    endtask

    task automatic test_timeout();
        clear_reqs();
        load(0, 32'h04030201, 32'h08070605);
        act[0] = 1'b1; stop_at[0] = 2;
`ifdef MAC_SCHED_TIMEOUT_EN
        run(60, 1);
        tests++;
        if (nres !== 1 || r_err[0] !== 1'b1 || r_data[0] !== 16'd0
            || r_sat[0] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_abort got n=%0d err=%b d=%h sat=%b",
                     nres, r_err[0], r_data[0], r_sat[0]);
        end
        tests++;
        if (r_cyc[0] !== 20 || clr_cnt !== 2) begin
            fails++;
            $display("FAIL timeout_timing got c=%0d clr=%0d want 20,2",
                     r_cyc[0], clr_cnt);
        end
`else
        run(100, 1);
        tests++;
        if (nres !== 0) begin
            fails++; $display("FAIL no_timeout got %0d results want 0", nres);
        end
        tests++;
        if (in_ready_0 !== 1'b1 || res_err !== 1'b0) begin
            fails++;
            $display("FAIL no_timeout_wait got rdy=%b err=%b want 1,0",
                     in_ready_0, res_err);
        end
`endif
        @(negedge clock);
        iv[0] = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        clear_reqs();
        test_reset();
        test_tie();
        test_single();
        test_back_to_back();
        test_saturate();
        test_gap();
        test_hold();
        test_reset_feed();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_job_scheduler.md
# mac_job_scheduler

Controller that shares one external pipelined saturating 8x8 MAC between two streaming requesters. It grants the MAC to one requester per job (round-robin) and clears the accumulator before each job. It then feeds exactly LEN operand pairs, waits for the MAC pipeline to drain, and returns the saturated 16-bit dot product with the requester ID. It sits between the operand producers and the MAC datapath.

## Interface
- LEN, 4: operand pairs per job (>=1).
- MAC_LAT, 3: cycles from an accepted operand pair until its contribution is visible on mac_sum.
- TIMEOUT, 16: idle-feed cycles before abort (used only with MAC_SCHED_TIMEOUT_EN).

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid_0 / in_valid_1  in  1  requester k has an operand pair.
- in_a_0, in_b_0 / in_a_1, in_b_1  in  8  operands of requester k.
- in_ready_0 / in_ready_1  out  1  pair accepted this cycle when valid&ready.
- mac_a, mac_b  out  8  operands to MAC (mux of granted requester).
- mac_en  out  1  MAC accumulates mac_a*mac_b this cycle.
- mac_clr  out  1  synchronous accumulator clear.
- mac_sum  in  16  saturated accumulator from MAC.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  16  captured dot product.
- res_id  out  1  requester that owns the result.
- res_sat  out  1  res_data == 16'hFFFF.
- res_err  out  1  job aborted (timeout build only; else constant 0).

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, RESULT.
- IDLE: if any in_valid_k, latch grant. On a tie, grant the requester not served last; last_grant resets to 1, so requester 0 wins the first tie. Then go to CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle. Then go to FEED with cnt=0.
- FEED: in_ready_g=1; the other in_ready is 0. mac_a/mac_b pass the granted operands combinationally. mac_en = in_valid_g & in_ready_g. Each accept increments cnt. On the accept with cnt==LEN-1, go to DRAIN with dcnt=MAC_LAT. Gaps (in_valid_g low) stall without penalty.
- DRAIN: no inputs accepted, mac_en=0. Decrement dcnt. When dcnt reaches 1, capture mac_sum into res_data on that edge, then go to RESULT.
- RESULT: res_valid=1. res_data, res_id and res_sat are held stable. On res_valid&res_ready, drop res_valid, update last_grant, and go to IDLE.
- Back-to-back jobs: always at least one IDLE cycle between jobs.
- Arithmetic: width and saturation are owned by the MAC. The block never modifies mac_sum. res_sat is derived from captured res_data.
- Reset (async, any state): state=IDLE, last_grant=1, cnt=dcnt=0. All outputs are 0: in_ready_k, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_id, res_sat, res_err. A partial job is discarded; the requester must resend the whole vector.

## Timing
- Request first seen in IDLE at cycle 0: CLEAR at cycle 1, FEED from cycle 2.
- With no gaps, the last pair is accepted at cycle LEN+1 and DRAIN covers cycles LEN+2 .. LEN+1+MAC_LAT.
- res_valid rises at cycle LEN+2+MAC_LAT (cycle 9 for the defaults).
- Each FEED gap cycle adds one cycle of latency.
- in_ready_k is registered from state; it is never combinationally dependent on in_valid_k.
- A request arriving during a job waits; it is not dropped, provided the requester holds in_valid.

## Configuration
- MAC_SCHED_TIMEOUT_EN defined:
  - In FEED, a counter counts consecutive cycles with in_valid_g=0 and resets on any accept.
  - When it reaches TIMEOUT, the job aborts. The block asserts mac_clr for one cycle and goes directly to RESULT with res_data=0, res_err=1, res_sat=0.
- MAC_SCHED_TIMEOUT_EN undefined:
  - No counter exists. FEED waits indefinitely and res_err is tied to 0.

## Test plan
All scenarios use LEN=4, MAC_LAT=3 and a cycle-accurate saturating MAC model.
- Requester 0 sends a={1,2,3,4}, b={5,6,7,8} with no gaps -> res_data=70, res_id=0, res_sat=0, res_valid at cycle 9, mac_clr high exactly once, at cycle 1.
- Both requesters valid at the same cycle right after reset -> requester 0 served first, then requester 1 (a={2,2,2,2}, b={3,3,3,3} -> res_data=24, res_id=1). On the next tie, requester 0 wins again.
- Requester 1 sends a=b=255 for all four pairs -> res_data=16'hFFFF, res_sat=1.
- Requester 0 vector from scenario 1 with in_valid_0 low for 2 cycles after the second pair -> mac_en low for those 2 cycles, res_data=70, res_valid at cycle 11.
- res_ready held low 5 cycles in RESULT -> outputs stable and no new grant while requester 1 waits. Separately, reset_n pulsed low during FEED -> all outputs 0 immediately, and a resent job yields the correct result.
- With MAC_SCHED_TIMEOUT_EN: requester 0 stops after 2 pairs for 16 cycles -> res_valid with res_err=1, res_data=0. Without the macro, no result appears within 100 cycles.
